// File: rtl/mod2011_pkg.sv
// Shared constants and FSM encoding for the mod-2011 residue accumulation path.
// Also imported by the wrappers around the upstream 6-input LUT stage.
package mod2011_pkg;

    localparam int MOD    = 2011;
    localparam int W      = 11;
    localparam int NTERMS = 84;
    localparam int CNT_W  = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/mod2011_addred.sv
// Combinational reduce-and-add: folds a raw chunk residue into [0, MOD),
// then adds it to a base below MOD with a single compare-subtract.
module mod2011_addred #(
    parameter int MOD = mod2011_pkg::MOD,
    parameter int W   = mod2011_pkg::W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         range_err
);

    localparam logic [W-1:0] MOD_W = MOD[W-1:0];

    logic [W-1:0] r;
    logic [W:0]   sum_w;

    assign range_err = (b >= MOD_W);
    assign r         = range_err ? (b - MOD_W) : b;
    assign sum_w     = {1'b0, a} + {1'b0, r};
    // The true result is below MOD, so W-bit wraparound arithmetic is exact.
    assign y         = (sum_w >= {1'b0, MOD_W}) ? (a + r - MOD_W) : (a + r);

endmodule

// File: rtl/mod2011_acc.sv
// Streaming accumulator: sums per-chunk residues of one operand mod MOD and
// holds the result, term count and error flag until the consumer takes it.
module mod2011_acc #(
    parameter int MOD    = mod2011_pkg::MOD,
    parameter int W      = mod2011_pkg::W,
    parameter int NTERMS = mod2011_pkg::NTERMS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_residue,
    input  logic         in_first,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_residue,
    output logic [6:0]   out_count,
    output logic         out_err
);

    import mod2011_pkg::*;

    localparam logic [6:0] CNT_MAX  = 7'd127;
    localparam logic [6:0] NTERMS_C = NTERMS[6:0];

    state_e       state_q, state_d;
    logic [W-1:0] acc_q, acc_d;
    logic [6:0]   cnt_q, cnt_d;
    logic         err_q, err_d;
    logic         live_q, live_d;

    logic         beat;
    logic         first;
    logic [W-1:0] base;
    logic [W-1:0] sum;
    logic         range_err;
    logic [6:0]   cnt_next;

    // live_q keeps in_ready low while reset is held, independent of state.
    assign in_ready = live_q && (state_q != HOLD);
    assign beat     = in_valid && in_ready;
    assign first    = in_first || (state_q == IDLE);
    assign base     = first ? '0 : acc_q;
    assign cnt_next = first ? 7'd1 : ((cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 7'd1);

    mod2011_addred #(
        .MOD(MOD),
        .W  (W)
    ) u_addred (
        .a        (base),
        .b        (in_residue),
        .y        (sum),
        .range_err(range_err)
    );

    always_comb begin
        // NOTE: every target gets its default first so no path infers a latch.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        live_d  = 1'b1;
        unique case (state_q)
            IDLE, ACC: begin
                if (beat) begin
                    acc_d   = sum;
                    cnt_d   = cnt_next;
                    err_d   = (!first && err_q) || range_err || (cnt_next > NTERMS_C);
                    state_d = in_last ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            live_q  <= live_d;
        end
    end

    // Results are read straight from the accumulator, which is frozen in HOLD.
    assign out_valid   = (state_q == HOLD);
    assign out_residue = acc_q;
    assign out_count   = cnt_q;
    assign out_err     = err_q;

endmodule

// File: tb/tb_mod2011_acc.sv
// Directed bench for mod2011_acc: an operand-level model checked every cycle,
// plus literal expectations for the hand-computed cases.
module tb_mod2011_acc;

    localparam int MOD    = 2011;
    localparam int NTERMS = 84;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_residue;
    logic        in_first;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_residue;
    logic [6:0]  out_count;
    logic        out_err;

    int n_tests = 0;
    int n_fail  = 0;

    mod2011_acc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_residue (in_residue),
        .in_first   (in_first),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_residue(out_residue),
        .out_count  (out_count),
        .out_err    (out_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Operand-level model: running sum of reduced terms, term total, range flag.
    int m_n     = 0;
    int m_sum   = 0;
    bit m_rerr  = 1'b0;
    bit m_hold  = 1'b0;
    bit m_active = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_n      = 0;
            m_sum    = 0;
            m_rerr   = 1'b0;
            m_hold   = 1'b0;
            m_active = 1'b0;
        end else begin
            check("cmp_out_valid", 32'(out_valid), 32'(m_hold));
            if (m_hold) begin
                check("cmp_residue", 32'(out_residue), m_sum);
                check("cmp_count", 32'(out_count), (m_n > 127) ? 127 : m_n);
                check("cmp_err", 32'(out_err), 32'(m_rerr || (m_n > NTERMS)));
                check("cmp_in_ready_hold", 32'(in_ready), 0);
                if (out_ready) begin
                    m_hold = 1'b0;
                end
            end else if (in_valid && in_ready) begin
                if (in_first || !m_active) begin
                    m_n    = 0;
                    m_sum  = 0;
                    m_rerr = 1'b0;
                end
                m_n++;
                m_sum = (m_sum + (int'(in_residue) % MOD)) % MOD;
                if (int'(in_residue) >= MOD) m_rerr = 1'b1;
                m_active = 1'b1;
                if (in_last) begin
                    m_hold   = 1'b1;
                    m_active = 1'b0;
                end
            end
        end
    end

    task automatic send(input int v, input bit f, input bit l);
        bit got;
        got        = 1'b0;
        in_valid   = 1'b1;
        in_residue = 11'(v);
        in_first   = f;
        in_last    = l;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_res(input string name, input int res, input int cnt, input int err);
        check({name, "_valid"}, 32'(out_valid), 1);
        check({name, "_residue"}, 32'(out_residue), res);
        check({name, "_count"}, 32'(out_count), cnt);
        check({name, "_err"}, 32'(out_err), err);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_valid"}, 32'(out_valid), 0);
        check({name, "_residue"}, 32'(out_residue), 0);
        check({name, "_count"}, 32'(out_count), 0);
        check({name, "_err"}, 32'(out_err), 0);
        check({name, "_in_ready"}, 32'(in_ready), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_residue = '0;
        in_first   = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b0;

        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 2010 + 1 wraps to 0; result one cycle after the last beat.
        send(2010, 1'b1, 1'b0);
        send(1, 1'b0, 1'b1);
        expect_res("wrap", 0, 2, 0);
        pop();

        // 84 x 2010 = 84 x (-1) mod 2011 = 1927.
        for (int i = 0; i < 84; i++) send(2010, i == 0, i == 83);
        expect_res("full84", 1927, 84, 0);
        pop();

        send(5, 1'b1, 1'b1);
        expect_res("single5", 5, 1, 0);
        pop();
        send(2047, 1'b1, 1'b1);
        expect_res("raw2047", 36, 1, 1);
        pop();

        // Backpressure: result frozen and input blocked for 10 cycles.
        send(100, 1'b1, 1'b0);
        send(200, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            expect_res("stall", 300, 2, 0);
            check("stall_in_ready", 32'(in_ready), 0);
        end
        pop();
        check("after_pop_valid", 32'(out_valid), 0);
        send(3, 1'b1, 1'b1);
        expect_res("after_pop", 3, 1, 0);
        pop();

        for (int i = 0; i < 85; i++) send(1, i == 0, i == 84);
        expect_res("over85", 85, 85, 1);
        pop();

        // in_first mid-operand discards the partial sum.
        send(10, 1'b1, 1'b0);
        send(20, 1'b0, 1'b0);
        send(7, 1'b1, 1'b0);
        send(1, 1'b0, 1'b1);
        expect_res("restart", 8, 2, 0);
        pop();

        // A beat in IDLE without in_first still starts an operand.
        send(9, 1'b0, 1'b0);
        send(4, 1'b0, 1'b1);
        expect_res("implicit_first", 13, 2, 0);
        pop();

        // Counter saturates at 127 while the sum keeps going.
        for (int i = 0; i < 130; i++) send(1, i == 0, i == 129);
        expect_res("saturate", 130, 127, 1);
        pop();

        // Reset while a result is pending discards it.
        send(5, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_hold");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset mid-operand, then a fresh operand.
        send(1, 1'b1, 1'b0);
        send(1, 1'b0, 1'b0);
        send(1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(7, 1'b1, 1'b0);
        send(8, 1'b0, 1'b1);
        expect_res("post_reset", 15, 2, 0);
        pop();

        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mod2011_acc.md
MOD2011_ACC -- requirements
Module: mod2011_acc

Interface
REQ-001 SHALL have parameter MOD, default 2011, the modulus; results lie in 0..MOD-1.
REQ-002 SHALL have parameter W, default 11, the residue width, equal to ceil(log2(MOD)).
REQ-003 SHALL have parameter NTERMS, default 84, the maximum number of terms per operand (500-bit operand in 6-bit chunks).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset: asynchronous assert, active-low.
REQ-006 SHALL have port in_valid, input, 1, the input term is valid.
REQ-007 SHALL have port in_ready, output, 1, the block accepts a term this cycle.
REQ-008 SHALL have port in_residue, input, W, a per-chunk residue from the upstream 6-input LUT stage.
REQ-009 SHALL have port in_first, input, 1, the term is the first of an operand.
REQ-010 SHALL have port in_last, input, 1, the term is the last of an operand.
REQ-011 SHALL have port out_valid, output, 1, the result is valid.
REQ-012 SHALL have port out_ready, input, 1, the consumer accepts the result.
REQ-013 SHALL have port out_residue, output, W, the operand value mod MOD.
REQ-014 SHALL have port out_count, output, 7, the number of terms summed.
REQ-015 SHALL have port out_err, output, 1, a range or count violation occurred in this operand.

Function
REQ-016 SHALL accept a term on any cycle where in_valid and in_ready are both high (a beat).
REQ-017 SHALL reduce each accepted term first: r = in_residue-MOD if in_residue>=MOD, else in_residue; it SHALL set the operand's error flag when that reduction occurs.
REQ-018 SHALL update acc on each beat to acc'=(base+r) mod MOD using one compare-subtract, where base is 0 on an in_first beat and acc otherwise; the W+1-bit sum never reaches 2*MOD.
REQ-019 SHALL implement an FSM with states IDLE, ACC, HOLD; reset state is IDLE.
REQ-020 IDLE: in_ready=1; a beat without in_first SHALL be treated as first; the FSM goes to ACC, or to HOLD if in_last.
REQ-021 ACC: in_ready=1; a beat with in_last goes to HOLD; a beat with in_first SHALL discard the partial sum, clear count and error, and restart.
REQ-022 HOLD: in_ready=0, out_valid=1; out_residue, out_count and out_err SHALL stay stable until out_ready; on out_ready the FSM goes to IDLE.
REQ-023 Latency SHALL be one cycle: out_valid rises on the cycle after the in_last beat.
REQ-024 A beat with both in_first and in_last SHALL produce a single-term result with out_count=1.
REQ-025 The term counter SHALL saturate at 127; when count exceeds NTERMS, the error flag SHALL be set while accumulation continues.
REQ-026 out_valid SHALL NOT be asserted in IDLE or ACC; no result is ever dropped under backpressure.

Reset
REQ-027 On rst_n low the block SHALL immediately set: FSM=IDLE, acc=0, count=0, error=0, out_valid=0, out_residue=0, out_count=0, out_err=0, in_ready=0 while reset is held.
REQ-028 A reset mid-operand or during HOLD SHALL discard all partial or pending results; the first beat after release starts a new operand.

Structure
REQ-029 MOD, W, NTERMS and the FSM state enum SHALL live in shared package mod2011_pkg, reused by the LUT stage's wrappers.
REQ-030 The combinational reduce-and-add SHALL be the sub-module mod2011_addred (inputs a,b < MOD plus raw-range flag; output (a+b) mod MOD).

Verification
REQ-031 Beats 2010(first), 1(last) -> out_residue=0, out_count=2, out_err=0, out_valid one cycle after last.
REQ-032 84 beats of 2010 (first on beat 1, last on beat 84) -> out_residue=1927, out_count=84, out_err=0.
REQ-033 Single beat 5 with first and last -> out_residue=5, out_count=1; then beat 2047 first+last -> out_residue=36, out_err=1.
REQ-034 out_ready held low 10 cycles in HOLD -> outputs stable and in_ready=0 throughout; release -> IDLE, next operand accepted.
REQ-035 85 beats of 1 with last on beat 85 -> out_residue=85, out_count=85, out_err=1.
REQ-036 rst_n pulsed low after 3 beats of an operand -> all outputs 0; new operand 7(first), 8(last) -> out_residue=15, out_count=2.
